// File: rtl/fixed_float_conversion.sv
// Converts between 32-bit two's-complement fixed point (programmable binary point)
// and IEEE-754 single precision, one registered result per clock.
module fixed_float_conversion (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] targetnumber,
  input  logic [4:0]  fixpointpos,
  input  logic        opcode,
  output logic [31:0] result
);

  localparam int unsigned DW      = 32;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned SIG_W   = 24;
  localparam int unsigned WIDE_W  = 64;
  localparam int unsigned K_W     = 11;

  logic [DW-1:0]     x2f_c;
  logic [DW-1:0]     f2x_c;
  logic [DW-1:0]     conv_c;

  logic [DW:0]       mag33;
  logic [DW-1:0]     mag;
  logic [4:0]        lead;
  logic [DW-2:0]     norm;
  logic [MANT_W-1:0] frac;
  logic [8:0]        exp9;

  logic [7:0]        fe;
  logic [MANT_W-1:0] fm;
  logic [SIG_W-1:0]  sig;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    nk;
  logic [WIDE_W-1:0] wide;
  logic              ovf;
  logic              pos_big;
  logic              neg_big;

  // Fixed to float: normalise on the leading one, mantissa truncated toward zero.
  always_comb begin
    mag33 = targetnumber[DW-1] ? (~{1'b1, targetnumber} + 33'd1) : {1'b0, targetnumber};
    mag   = DW'(mag33);
    lead  = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    norm  = 31'(mag << (5'd31 - lead));
    frac  = MANT_W'(norm >> 8);
    exp9  = 9'd127 + 9'(lead) - 9'(fixpointpos);
    if (mag == '0) x2f_c = '0;
    else           x2f_c = {targetnumber[DW-1], exp9[7:0], frac};
  end

  // Float to fixed: scale the significand, truncate, then saturate by sign.
  always_comb begin
    fe   = targetnumber[30:23];
    fm   = targetnumber[22:0];
    sig  = {1'b1, fm};
    k    = K_W'(fe) + K_W'(fixpointpos) - K_W'(150);
    nk   = K_W'(0) - k;
    wide = '0;
    ovf  = 1'b0;
    if (k[K_W-1]) begin
      if (nk < K_W'(SIG_W)) wide = WIDE_W'(sig >> nk[4:0]);
    end else if (k > K_W'(40)) begin
      ovf = 1'b1;
    end else begin
      wide = WIDE_W'(sig) << k[5:0];
    end
    pos_big = ovf || (wide > 64'h0000_0000_7FFF_FFFF);
    neg_big = ovf || (wide >= 64'h0000_0000_8000_0000);

    if (fe == 8'hFF) begin
      f2x_c = (targetnumber[DW-1] && fm == '0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (fe == 8'h00) begin
      f2x_c = '0;
    end else if (targetnumber[DW-1]) begin
      f2x_c = neg_big ? 32'h8000_0000 : (~DW'(wide) + 32'd1);
    end else begin
      f2x_c = pos_big ? 32'h7FFF_FFFF : DW'(wide);
    end
  end

  assign conv_c = opcode ? f2x_c : x2f_c;

  always_ff @(posedge clk) begin
    if (rst) result <= '0;
    else     result <= conv_c;
  end

endmodule

// File: tb/tb_fixed_float_conversion.sv
// Directed plus randomized checks of fixed_float_conversion against a numeric model.
module tb_fixed_float_conversion;

  logic        clk;
  logic        rst;
  logic [31:0] targetnumber;
  logic [4:0]  fixpointpos;
  logic        opcode;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  fixed_float_conversion dut (
    .clk         (clk),
    .rst         (rst),
    .targetnumber(targetnumber),
    .fixpointpos (fixpointpos),
    .opcode      (opcode),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: fixed value x / 2^fp expressed as a float with truncated mantissa.
  function automatic logic [31:0] m_fx2fl(input logic [31:0] x, input int fp);
    longint mag;
    longint mant;
    int     p;
    logic [7:0] ex;
    mag = longint'($signed(x));
    if (mag < 0) mag = -mag;
    if (mag == 0) return 32'h0;
    p = 0;
    while ((longint'(2) ** (p + 1)) <= mag) p++;
    mant = (mag * 64'd8388608) / (longint'(2) ** p) - 64'd8388608;
    ex   = 8'(127 + p - fp);
    return {x[31], ex, 23'(mant)};
  endfunction

  // Model: real value of the float times 2^fp, truncated toward zero and clamped.
  function automatic logic [31:0] m_fl2fx(input logic [31:0] f, input int fp);
    int  e;
    int  m;
    real v;
    e = int'(f[30:23]);
    m = int'(f[22:0]);
    if (e == 255) begin
      if (m != 0) return 32'h7FFF_FFFF;
      return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    if (e == 0) return 32'h0;
    v = real'(8388608 + m) * (2.0 ** (e - 150 + fp));
    if (f[31]) v = -v;
    if (v >= 2147483648.0)  return 32'h7FFF_FFFF;
    if (v <= -2147483648.0) return 32'h8000_0000;
    return 32'($rtoi(v));
  endfunction

  task automatic step(input logic op, input int fp, input logic [31:0] tn,
                      input logic [31:0] expv, input string tag);
    opcode       = op;
    fixpointpos  = 5'(fp);
    targetnumber = tn;
    @(posedge clk);
    #1;
    total++;
    assert (result === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h (op=%0d fp=%0d in=%h)", tag, result, expv, op, fp, tn);
      end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] f;
    int          fp;

    rst = 1'b1;
    opcode = 1'b1;
    fixpointpos = 5'd13;
    targetnumber = 32'hDEAD_BEEF;
    @(posedge clk);
    targetnumber = 32'h1234_5678;
    opcode = 1'b0;
    @(posedge clk);
    #1;
    total++;
    assert (result === 32'h0)
      else begin
        bad++;
        $error("FAIL reset observed=%h expected=%h", result, 32'h0);
      end
    rst = 1'b0;

    step(1'b0, 2, 32'h0000_0065, 32'h41CA_0000, "fx2fl_25p25");
    step(1'b0, 7, 32'h0000_0065, 32'h3F4A_0000, "fx2fl_0p789");
    step(1'b0, 0, 32'hFFFF_FFFF, 32'hBF80_0000, "fx2fl_m1");
    step(1'b0, 0, 32'h8000_0000, 32'hCF00_0000, "fx2fl_min");
    step(1'b1, 2, 32'h41CA_0000, 32'h0000_0065, "fl2fx_25p25");
    step(1'b1, 0, 32'hBF80_0000, 32'hFFFF_FFFF, "fl2fx_m1");
    step(1'b1, 0, 32'h3FC0_0000, 32'h0000_0001, "fl2fx_trunc");
    step(1'b0, 5, 32'h0000_0000, 32'h0000_0000, "fx2fl_zero");
    step(1'b1, 3, 32'h8000_0000, 32'h0000_0000, "fl2fx_negzero");
    step(1'b1, 3, 32'h0000_0001, 32'h0000_0000, "fl2fx_denorm");
    step(1'b1, 0, 32'h7FC0_0000, 32'h7FFF_FFFF, "fl2fx_nan");
    step(1'b1, 0, 32'h4F80_0000, 32'h7FFF_FFFF, "fl2fx_sat_pos");
    step(1'b1, 0, 32'hCF00_0000, 32'h8000_0000, "fl2fx_min");
    step(1'b1, 0, 32'hFF80_0000, 32'h8000_0000, "fl2fx_ninf");
    step(1'b1, 0, 32'h7F80_0000, 32'h7FFF_FFFF, "fl2fx_pinf");
    step(1'b1, 0, 32'h3F00_0000, 32'h0000_0000, "fl2fx_half");
    step(1'b1, 31, 32'hC000_0000, 32'h8000_0000, "fl2fx_sat_neg");

    for (int i = 0; i < 40; i++) begin
      x  = $urandom;
      fp = int'($urandom_range(0, 31));
      if (i % 4 == 0) x = x >> $urandom_range(0, 31);
      step(1'b0, fp, x, m_fx2fl(x, fp), "rand_fx2fl");
    end

    for (int i = 0; i < 40; i++) begin
      f  = $urandom;
      fp = int'($urandom_range(0, 31));
      if (i % 2 == 0) f[30:23] = 8'(int'($urandom_range(96, 160)));
      step(1'b1, fp, f, m_fl2fx(f, fp), "rand_fl2fx");
    end

    for (int i = 0; i < 30; i++) begin
      x  = 32'($urandom_range(0, 32'h00FF_FFFF));
      if ($urandom_range(0, 1) == 1) x = -x;
      fp = int'($urandom_range(0, 31));
      f  = m_fx2fl(x, fp);
      step(1'b0, fp, x, f, "rt_fx2fl");
      step(1'b1, fp, f, x, "rt_fl2fx");
      if (i == 15) begin
        rst = 1'b1;
        step(1'b0, 2, 32'h0000_0065, 32'h0000_0000, "rst_mid");
        rst = 1'b0;
        step(1'b0, 2, 32'h0000_0065, 32'h41CA_0000, "rst_resume");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_float_conversion.md
Name: fixed_float_conversion

Overview:
- Bidirectional converter between 32-bit two's-complement fixed point and IEEE-754 single precision.
- The binary point position is programmable at run time.
- Single-cycle registered datapath block, selected per sample by `opcode`.
- Intended as an arithmetic helper in the datapath; no handshake, one result per clock.

Parameters:
- None. All widths are fixed at 32-bit data and 5-bit binary-point position.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- targetnumber  input  32  operand: a fixed-point value when opcode=0, an IEEE-754 float when opcode=1.
- fixpointpos  input  5  number of fractional bits in the fixed-point format (0..31).
- opcode  input  1  0 = fixed to float; 1 = float to fixed.
- result  output  32  registered conversion result.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - On a rising clk edge with rst=1, result is set to 0x00000000.
  - rst has priority over any conversion in progress; there is no other state.
- Timing:
  - Inputs are sampled on every rising edge with rst=0.
  - result = conversion of the sampled inputs, visible after that edge.
  - Latency is 1 cycle. result holds until the next edge.
  - Fully combinational conversion logic feeds a 32-bit output register. No pipeline stages, no valid or ready.
- opcode=0, fixed to float:
  - Input is a signed 32-bit value equal to targetnumber / 2^fixpointpos.
  - Zero input gives 0x00000000 (+0).
  - Sign bit = targetnumber[31]. Magnitude = |targetnumber|, computed 33 bits wide so 0x80000000 gives magnitude 2^31.
  - p = index of the leading one in the magnitude (0..31).
  - Exponent field = 127 + p - fixpointpos. This is always in range 96..158, so no overflow or denormal handling is needed.
  - Mantissa = the 23 bits immediately below the leading one.
    - If p < 23, left-align and zero-fill.
    - If p > 23, truncate the discarded low bits (round toward zero).
- opcode=1, float to fixed:
  - Fields: s = bit 31, e = bits 30:23, m = bits 22:0. Significand = {1, m}, 24 bits.
  - e = 0 (zero or denormal) gives 0x00000000.
  - Shift k = e - 127 + fixpointpos - 23.
    - If k < 0, shift the significand right by -k. Bits shifted out are truncated toward zero; a shift of 24 or more gives 0.
    - If k >= 0, shift left by k, using a 64-bit or wider intermediate to detect overflow.
  - If s = 1, negate the magnitude (two's complement).
  - Saturation:
    - Positive magnitude above 2^31-1 gives 0x7FFFFFFF.
    - Negative magnitude above 2^31 gives 0x80000000.
    - Negative magnitude exactly 2^31 gives 0x80000000.
  - e = 255: Inf gives 0x7FFFFFFF or 0x80000000 by sign; NaN gives 0x7FFFFFFF.
  - -0.0 gives 0x00000000.
- Changing opcode or fixpointpos takes effect on the next edge. There is no interaction between consecutive samples.

Test Plan:
- rst=1 for 2 edges with arbitrary inputs -> result = 0x00000000. Release rst; opcode=0, fixpointpos=2, targetnumber=0x00000065 (25.25) -> 0x41CA0000 one edge later.
- opcode=0, fixpointpos=7, targetnumber=0x00000065 (0.7890625) -> 0x3F4A0000. Then fixpointpos=0, targetnumber=0xFFFFFFFF (-1) -> 0xBF800000. Then targetnumber=0x80000000, fixpointpos=0 -> 0xCF000000.
- opcode=1, fixpointpos=2, targetnumber=0x41CA0000 -> 0x00000065. Then fixpointpos=0, targetnumber=0xBF800000 -> 0xFFFFFFFF. Then fixpointpos=0, targetnumber=0x3FC00000 (1.5) -> 0x00000001 (truncation).
- Zero and special cases:
  - opcode=0, targetnumber=0 -> 0x00000000.
  - opcode=1, 0x80000000 -> 0x00000000.
  - opcode=1, 0x00000001 (denormal) -> 0x00000000.
  - opcode=1, 0x7FC00000 (NaN) -> 0x7FFFFFFF.
- Saturation, opcode=1, fixpointpos=0:
  - 0x4F800000 (2^32) -> 0x7FFFFFFF.
  - 0xCF000000 (-2^31) -> 0x80000000.
  - 0xFF800000 (-Inf) -> 0x80000000.
- Round trip and reset: for random fixed values with |x| < 2^24 and random fixpointpos, fixed to float then float to fixed returns x exactly. Asserting rst on one edge mid-stream forces result = 0 on that edge; conversions resume on the next edge.
